// File: rtl/touch_led_ctrl.sv
// Touch-key LED controller: synchronizes and debounces a touch sensor, classifies
// accepted presses as short or long, and steps an LED mode (off/on/slow/fast blink).
module touch_led_ctrl #(
  parameter int unsigned DEB_CYCLES  = 1_000_000,
  parameter int unsigned LONG_CYCLES = 50_000_000,
  parameter int unsigned SLOW_HALF   = 25_000_000,
  parameter int unsigned FAST_HALF   = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       touch_key,
  output logic       led,
  output logic [1:0] mode,
  output logic       short_press,
  output logic       long_press
);

  localparam int unsigned DebW     = $clog2(DEB_CYCLES);
  localparam int unsigned HoldW    = $clog2(LONG_CYCLES + 1);
  localparam int unsigned BlinkMax = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int unsigned BlinkW   = $clog2(BlinkMax);

  localparam logic [DebW-1:0]   DebLast  = DebW'(DEB_CYCLES - 1);
  localparam logic [HoldW-1:0]  HoldLast = HoldW'(LONG_CYCLES - 1);
  localparam logic [HoldW-1:0]  HoldSat  = HoldW'(LONG_CYCLES);
  localparam logic [BlinkW-1:0] SlowLast = BlinkW'(SLOW_HALF - 1);
  localparam logic [BlinkW-1:0] FastLast = BlinkW'(FAST_HALF - 1);

  localparam logic [1:0] ModeOff  = 2'd0;
  localparam logic [1:0] ModeOn   = 2'd1;
  localparam logic [1:0] ModeSlow = 2'd2;

  typedef enum logic [2:0] {StIdle, StDebP, StPressed, StLong, StDebR} state_t;

  logic              r_sync, r_key_s, r_armed;
  logic [1:0]        r_vld;
  state_t            r_state, w_state_nxt;
  logic [DebW-1:0]   r_deb_cnt, w_deb_nxt;
  logic [HoldW-1:0]  r_hold_cnt, w_hold_nxt;
  logic              r_tag_long, w_tag_nxt;
  logic              r_short, w_short_nxt;
  logic              r_long, w_long_nxt;
  logic [1:0]        r_mode, w_mode_nxt;
  logic              r_mode_chg;
  logic              r_led, w_led_nxt;
  logic [BlinkW-1:0] r_blink_cnt, w_blink_nxt;
  logic [BlinkW-1:0] w_half_last;

  // Two-flop synchronizer; r_armed demands a low key after reset so a key held
  // through reset cannot start a press until it has been released once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 1'b0;
      r_key_s <= 1'b0;
      r_vld   <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_sync  <= touch_key;
      r_key_s <= r_sync;
      r_vld   <= {r_vld[0], 1'b1};
      r_armed <= r_armed | (r_vld[1] & ~r_key_s);
    end
  end

  // Press FSM next-state, counters and press pulses.
  always_comb begin
    w_state_nxt = r_state;
    w_deb_nxt   = r_deb_cnt;
    w_hold_nxt  = r_hold_cnt;
    w_tag_nxt   = r_tag_long;
    w_short_nxt = 1'b0;
    w_long_nxt  = 1'b0;
    case (r_state)
      StIdle: begin
        if (r_armed && r_key_s) begin
          w_state_nxt = StDebP;
          w_deb_nxt   = '0;
        end
      end
      StDebP: begin
        if (!r_key_s) begin
          w_state_nxt = StIdle;
        end else if (r_deb_cnt == DebLast) begin
          w_state_nxt = StPressed;
          w_hold_nxt  = '0;
        end else begin
          w_deb_nxt = r_deb_cnt + DebW'(1);
        end
      end
      StPressed: begin
        if (!r_key_s) begin
          w_state_nxt = StDebR;
          w_deb_nxt   = '0;
          w_tag_nxt   = 1'b0;
        end else if (r_hold_cnt >= HoldLast) begin
          w_state_nxt = StLong;
          w_hold_nxt  = HoldSat;
          w_long_nxt  = 1'b1;
        end else begin
          w_hold_nxt = r_hold_cnt + HoldW'(1);
        end
      end
      StLong: begin
        if (!r_key_s) begin
          w_state_nxt = StDebR;
          w_deb_nxt   = '0;
          w_tag_nxt   = 1'b1;
        end
      end
      StDebR: begin
        if (r_key_s) begin
          // Bounce: resume where we came from, hold count untouched.
          w_state_nxt = r_tag_long ? StLong : StPressed;
        end else if (r_deb_cnt == DebLast) begin
          w_state_nxt = StIdle;
          w_short_nxt = ~r_tag_long;
        end else begin
          w_deb_nxt = r_deb_cnt + DebW'(1);
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Mode steps on the same edge that registers a press pulse.
  always_comb begin
    w_mode_nxt = r_mode;
    if (w_long_nxt) begin
      w_mode_nxt = ModeOff;
    end else if (w_short_nxt) begin
      w_mode_nxt = r_mode + 2'd1;
    end
  end

  // LED follows the mode one edge late; a mode change restarts the blink phase high.
  always_comb begin
    w_led_nxt   = r_led;
    w_blink_nxt = r_blink_cnt;
    w_half_last = (r_mode == ModeSlow) ? SlowLast : FastLast;
    if (r_mode_chg) begin
      w_blink_nxt = '0;
      w_led_nxt   = (r_mode != ModeOff);
    end else if (r_mode == ModeOff) begin
      w_blink_nxt = '0;
      w_led_nxt   = 1'b0;
    end else if (r_mode == ModeOn) begin
      w_blink_nxt = '0;
      w_led_nxt   = 1'b1;
    end else if (r_blink_cnt >= w_half_last) begin
      w_blink_nxt = '0;
      w_led_nxt   = ~r_led;
    end else begin
      w_blink_nxt = r_blink_cnt + BlinkW'(1);
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_deb_cnt   <= '0;
      r_hold_cnt  <= '0;
      r_tag_long  <= 1'b0;
      r_short     <= 1'b0;
      r_long      <= 1'b0;
      r_mode      <= ModeOff;
      r_mode_chg  <= 1'b0;
      r_led       <= 1'b0;
      r_blink_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_deb_cnt   <= w_deb_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_tag_long  <= w_tag_nxt;
      r_short     <= w_short_nxt;
      r_long      <= w_long_nxt;
      r_mode      <= w_mode_nxt;
      r_mode_chg  <= (w_mode_nxt != r_mode);
      r_led       <= w_led_nxt;
      r_blink_cnt <= w_blink_nxt;
    end
  end

  assign led         = r_led;
  assign mode        = r_mode;
  assign short_press = r_short;
  assign long_press  = r_long;

endmodule

// File: tb/tb_touch_led_ctrl.sv
// Bench for touch_led_ctrl: vector table, hand sequences for timing corners, and
// random key traffic checked every cycle against a run-length reference model.
module tb_touch_led_ctrl;

  localparam int Deb  = 4;
  localparam int Long = 20;
  localparam int Slow = 8;
  localparam int Fast = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       touch_key = 1'b0;
  logic       led;
  logic [1:0] mode;
  logic       short_press;
  logic       long_press;

  int n_checks = 0;
  int n_errors = 0;

  touch_led_ctrl #(
    .DEB_CYCLES (Deb),
    .LONG_CYCLES(Long),
    .SLOW_HALF  (Slow),
    .FAST_HALF  (Fast)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .touch_key  (touch_key),
    .led        (led),
    .mode       (mode),
    .short_press(short_press),
    .long_press (long_press)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Key is the raw input seen two edges late; presses/releases are accepted on run
  // lengths of Deb+1 samples; a long press is the Long-th held sample while down.
  int   m_k, m_hi_run, m_lo_run, m_hold, m_mode, m_tchg;
  logic m_p1, m_p2, m_ks, m_armed, m_down, m_is_long, m_short, m_long, m_led;
  int   m_new;

  function automatic logic model_led(input int md, input int d);
    case (md)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return ((d / Slow) % 2) == 0;
      default: return ((d / Fast) % 2) == 0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_k = 0; m_hi_run = 0; m_lo_run = 0; m_hold = 0; m_mode = 0; m_tchg = 0;
      m_p1 = 0; m_p2 = 0; m_armed = 0; m_down = 0; m_is_long = 0;
      m_short = 0; m_long = 0; m_led = 0;
    end else begin
      m_k++;
      m_ks = (m_k >= 3) ? m_p2 : 1'b0;
      m_led = model_led(m_mode, m_k - m_tchg - 1);
      m_short = 0;
      m_long = 0;
      if (!m_down) begin
        if (m_armed && m_ks) begin
          m_hi_run++;
          if (m_hi_run == Deb + 1) begin
            m_down = 1; m_hold = 0; m_lo_run = 0; m_is_long = 0; m_hi_run = 0;
          end
        end else begin
          m_hi_run = 0;
        end
      end else if (m_ks) begin
        if (m_lo_run == 0 && !m_is_long) begin
          m_hold++;
          if (m_hold == Long) begin
            m_is_long = 1;
            m_long = 1;
          end
        end
        m_lo_run = 0;
      end else begin
        m_lo_run++;
        if (m_lo_run == Deb + 1) begin
          m_down = 0;
          m_short = !m_is_long;
          m_hi_run = 0;
        end
      end
      if (m_k >= 3 && !m_ks) m_armed = 1;
      m_new = m_long ? 0 : (m_short ? (m_mode + 1) % 4 : m_mode);
      if (m_new != m_mode) begin
        m_mode = m_new;
        m_tchg = m_k;
      end
      m_p2 = m_p1;
      m_p1 = touch_key;
    end
    #1;
    n_checks++;
    if ({led, mode, short_press, long_press} !== {m_led, 2'(m_mode), m_short, m_long}) begin
      n_errors++;
      $display("FAIL model t=%0t: got led/mode/short/long %b required %b", $time,
               {led, mode, short_press, long_press}, {m_led, 2'(m_mode), m_short, m_long});
    end
  end

  // ---------------- stimulus helpers ----------------
  int t_short, t_long, t_long_at, t_cyc;

  task automatic sample();
    @(posedge clk);
    #1;
    t_cyc++;
    if (short_press) t_short++;
    if (long_press) begin
      t_long++;
      if (t_long_at == 0) t_long_at = t_cyc;
    end
  endtask

  task automatic clear_tally();
    t_short = 0; t_long = 0; t_long_at = 0; t_cyc = 0;
  endtask

  task automatic drive(input logic k, input int n);
    touch_key = k;
    repeat (n) sample();
  endtask

  task automatic count_run(input logic v, output int n);
    n = 0;
    while (led === v && n < 60) begin
      n++;
      sample();
    end
  endtask

  // Release the key, wait for the mode to reach m, then measure the blink phases.
  task automatic watch_entry(input int m, input int half);
    int found, n;
    found = 0;
    touch_key = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (mode == 2'(m)) begin
        found = 1;
        break;
      end
    end
    check($sformatf("enter_mode%0d", m), found, 1);
    sample();
    check($sformatf("led_on_entry_mode%0d", m), int'(led), 1);
    count_run(1'b1, n);
    check($sformatf("blink_high1_mode%0d", m), n, half);
    count_run(1'b0, n);
    check($sformatf("blink_low_mode%0d", m), n, half);
    count_run(1'b1, n);
    check($sformatf("blink_high2_mode%0d", m), n, half);
  endtask

  typedef struct {
    int hi;
    int lo;
    int n_short;
    int n_long;
    int mode;
    int led;      // -1: blink phase, not checked here
    int long_at;  // 0: not checked
  } vec_t;

  vec_t vecs[9];

  initial begin
    int at, n;
    // Long pulse lands 2 (sync) + 1 (idle) + Deb + Long samples after the key rises.
    vecs[0] = '{10, 10, 1, 0, 1,  1,  0};
    vecs[1] = '{ 3, 10, 0, 0, 1,  1,  0};
    vecs[2] = '{10, 10, 1, 0, 2, -1,  0};
    vecs[3] = '{10, 10, 1, 0, 3, -1,  0};
    vecs[4] = '{10, 10, 1, 0, 0,  0,  0};
    vecs[5] = '{10, 10, 1, 0, 1,  1,  0};
    vecs[6] = '{10, 10, 1, 0, 2, -1,  0};
    vecs[7] = '{40, 10, 0, 1, 0,  0, 27};
    vecs[8] = '{40, 10, 0, 1, 0,  0, 27};

    clear_tally();
    repeat (3) sample();
    check("reset_outputs", int'({led, mode, short_press, long_press}), 0);
    rst_n = 1'b1;
    drive(1'b0, 5);

    foreach (vecs[i]) begin
      clear_tally();
      drive(1'b1, vecs[i].hi);
      drive(1'b0, vecs[i].lo);
      check($sformatf("vec%0d_short", i), t_short, vecs[i].n_short);
      check($sformatf("vec%0d_long", i), t_long, vecs[i].n_long);
      check($sformatf("vec%0d_mode", i), int'(mode), vecs[i].mode);
      if (vecs[i].led >= 0) check($sformatf("vec%0d_led", i), int'(led), vecs[i].led);
      if (vecs[i].long_at != 0) check($sformatf("vec%0d_long_at", i), t_long_at, vecs[i].long_at);
    end

    // Blink periods in slow and fast modes.
    drive(1'b1, 10);
    drive(1'b0, 10);
    check("blink_pre_mode", int'(mode), 1);
    drive(1'b1, 10);
    watch_entry(2, Slow);
    drive(1'b1, 10);
    watch_entry(3, Fast);
    drive(1'b1, 10);
    drive(1'b0, 10);
    check("blink_wrap_mode", int'(mode), 0);

    // Release bounce: one short press, only after a full stable low.
    clear_tally();
    drive(1'b1, 10);
    drive(1'b0, 2);
    drive(1'b1, 2);
    touch_key = 1'b0;
    at = 0;
    for (int i = 1; i <= 20; i++) begin
      sample();
      if (short_press) begin
        at = i;
        break;
      end
    end
    check("bounce_short_at", at, 2 + 1 + Deb);
    drive(1'b0, 5);
    check("bounce_short_count", t_short, 1);
    check("bounce_mode", int'(mode), 1);

    // Reset mid-hold with the key still pressed.
    drive(1'b1, 15);
    rst_n = 1'b0;
    #2;
    check("reset_async_outputs", int'({led, mode, short_press, long_press}), 0);
    drive(1'b1, 2);
    check("reset_held_outputs", int'({led, mode, short_press, long_press}), 0);
    rst_n = 1'b1;
    clear_tally();
    drive(1'b1, 60);
    check("post_reset_hold_long", t_long, 0);
    drive(1'b0, 10);
    check("post_reset_release_short", t_short, 0);
    check("post_reset_mode", int'(mode), 0);
    clear_tally();
    drive(1'b1, 40);
    drive(1'b0, 10);
    check("new_press_long", t_long, 1);
    check("new_press_long_at", t_long_at, 2 + 1 + Deb + Long);
    check("new_press_short", t_short, 0);

    // Random key traffic with occasional resets, checked by the model every cycle.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 14) == 0) begin
        rst_n = 1'b0;
        drive(touch_key, 2);
        rst_n = 1'b1;
      end
      n = $urandom_range(1, 45);
      drive(1'b1, n);
      n = $urandom_range(1, 25);
      drive(1'b0, n);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
